// File: rtl/ga_pkg.sv
// Shared constants and types for the Gate Array sync/interrupt block.
package ga_pkg;
    localparam int INT_LINES = 52;
    localparam int H_DELAY   = 2;
    localparam int H_WIDTH   = 4;
    localparam int V_DELAY   = 2;
    localparam int V_WIDTH   = 26;

    typedef logic [1:0] mode_t;
endpackage

// File: rtl/ga_sync_int_if.sv
// Bundle of CRTC sync inputs, CPU-side controls and the conditioned outputs.
interface ga_sync_int_if;
    import ga_pkg::mode_t;

    logic       CLKEN;
    logic       HSYNC_IN;
    logic       VSYNC_IN;
    logic       INT_ACK;
    logic       INT_CLR;
    mode_t      MODE_IN;
    logic       INT;
    logic       HSYNC_OUT;
    logic       VSYNC_OUT;
    mode_t      MODE;
    logic [5:0] LINE_CNT;

    modport master (
        output CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR, MODE_IN,
        input  INT, HSYNC_OUT, VSYNC_OUT, MODE, LINE_CNT
    );

    modport slave (
        input  CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR, MODE_IN,
        output INT, HSYNC_OUT, VSYNC_OUT, MODE, LINE_CNT
    );
endinterface

// File: rtl/ga_sync_edge.sv
// Character-rate sampler for one CRTC sync line with rise/fall strobes.
module ga_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic clken,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic sample_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= 1'b0;
            prev_reg   <= 1'b0;
        end else if (clken) begin
            sample_reg <= din;
            prev_reg   <= sample_reg;
        end
    end

    assign level = sample_reg;
    assign rise  = clken & sample_reg & ~prev_reg;
    assign fall  = clken & ~sample_reg & prev_reg;
endmodule

// File: rtl/ga_sync_int.sv
// CPC Gate Array sync processor: 52-line interrupt counter with VSYNC resync,
// monitor HSYNC/VSYNC shaping and line-aligned screen mode latch.
module ga_sync_int
    import ga_pkg::mode_t;
#(
    parameter int INT_LINES = ga_pkg::INT_LINES,
    parameter int H_DELAY   = ga_pkg::H_DELAY,
    parameter int H_WIDTH   = ga_pkg::H_WIDTH,
    parameter int V_DELAY   = ga_pkg::V_DELAY,
    parameter int V_WIDTH   = ga_pkg::V_WIDTH
) (
    input  logic         CLOCK,
    input  logic         nRESET,
    ga_sync_int_if.slave bus
);
    localparam int HS = 0;
    localparam int VS = 1;

    logic [1:0] sync_in, sync_level, sync_rise, sync_fall;
    assign sync_in = {bus.VSYNC_IN, bus.HSYNC_IN};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_edge
            ga_sync_edge u_edge (
                .clk   (CLOCK),
                .rst_n (nRESET),
                .clken (bus.CLKEN),
                .din   (sync_in[gi]),
                .level (sync_level[gi]),
                .rise  (sync_rise[gi]),
                .fall  (sync_fall[gi])
            );
        end
    endgenerate

    logic h_rise, h_fall, h_level, v_rise, v_fall, v_level;
    assign h_rise  = sync_rise[HS];
    assign h_fall  = sync_fall[HS];
    assign h_level = sync_level[HS];
    assign v_rise  = sync_rise[VS];
    assign v_fall  = sync_fall[VS];
    assign v_level = sync_level[VS];

    logic [5:0] line_reg, line_next;
    logic       int_reg, int_next;
    logic       hs_reg, hs_next;
    logic       vs_reg, vs_next;
    mode_t      mode_reg, mode_next;
    logic [2:0] hdly_reg, hdly_next;
    logic [2:0] hw_reg, hw_next;
    logic [1:0] vdly_reg, vdly_next;
    logic [4:0] vw_reg, vw_next;
    logic       raise;
    logic       resync;

    // The VSYNC delay completes on the HSYNC fall that takes vdly from 1 to 0.
    assign resync = h_fall && (vdly_reg == 2'd1) && v_level;

    always_comb begin
        line_next = line_reg;
        int_next  = int_reg;
        hs_next   = hs_reg;
        vs_next   = vs_reg;
        mode_next = mode_reg;
        hdly_next = hdly_reg;
        hw_next   = hw_reg;
        vdly_next = vdly_reg;
        vw_next   = vw_reg;
        raise     = 1'b0;

        if (h_rise) begin
            mode_next = bus.MODE_IN;
            hdly_next = 3'(H_DELAY);
            hs_next   = 1'b0;
            hw_next   = '0;
        end else if (h_fall) begin
            hdly_next = '0;
            hs_next   = 1'b0;
            hw_next   = '0;
        end else if (bus.CLKEN) begin
            if (hdly_reg != 3'd0) begin
                hdly_next = hdly_reg - 3'd1;
                if (hdly_reg == 3'd1 && h_level) begin
                    hs_next = 1'b1;
                    hw_next = 3'(H_WIDTH);
                end
            end
            if (hs_reg) begin
                hw_next = (hw_reg != 3'd0) ? hw_reg - 3'd1 : 3'd0;
                if (hw_reg <= 3'd1) hs_next = 1'b0;
            end
        end

        if (v_rise) begin
            vdly_next = 2'(V_DELAY);
        end else if (v_fall) begin
            vdly_next = '0;
            vs_next   = 1'b0;
            vw_next   = '0;
        end else if (h_fall && vdly_reg != 2'd0) begin
            vdly_next = vdly_reg - 2'd1;
        end

        if (resync) begin
            vs_next   = 1'b1;
            vw_next   = 5'(V_WIDTH);
            line_next = '0;
            if (!line_reg[5]) begin
                int_next = 1'b1;
                raise    = 1'b1;
            end
        end else if (h_fall) begin
            if (vs_reg && !v_fall) begin
                vw_next = (vw_reg != 5'd0) ? vw_reg - 5'd1 : 5'd0;
                if (vw_reg <= 5'd1) vs_next = 1'b0;
            end
            if (line_reg == 6'(INT_LINES - 1)) begin
                line_next = '0;
                int_next  = 1'b1;
                raise     = 1'b1;
            end else begin
                line_next = line_reg + 6'd1;
            end
        end

        // A raising edge outranks ACK; CLR outranks everything.
        if (bus.INT_ACK && !raise) begin
            int_next     = 1'b0;
            line_next[5] = 1'b0;
        end
        if (bus.INT_CLR) begin
            int_next  = 1'b0;
            line_next = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge nRESET) begin
        if (!nRESET) begin
            line_reg <= '0;
            int_reg  <= 1'b0;
            hs_reg   <= 1'b0;
            vs_reg   <= 1'b0;
            mode_reg <= '0;
            hdly_reg <= '0;
            hw_reg   <= '0;
            vdly_reg <= '0;
            vw_reg   <= '0;
        end else begin
            line_reg <= line_next;
            int_reg  <= int_next;
            hs_reg   <= hs_next;
            vs_reg   <= vs_next;
            mode_reg <= mode_next;
            hdly_reg <= hdly_next;
            hw_reg   <= hw_next;
            vdly_reg <= vdly_next;
            vw_reg   <= vw_next;
        end
    end

    assign bus.INT       = int_reg;
    assign bus.HSYNC_OUT = hs_reg;
    assign bus.VSYNC_OUT = vs_reg;
    assign bus.MODE      = mode_reg;
    assign bus.LINE_CNT  = line_reg;
endmodule

// File: tb/tb_ga_sync_int.sv
// Line-level self-checking bench for ga_sync_int: directed sequences, a width
// table for the monitor HSYNC shaper and randomized lines against a model.
module tb_ga_sync_int;
    import ga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ga_sync_int_if bus ();
    ga_sync_int dut (.CLOCK(clk), .nRESET(rst_n), .bus(bus));

    typedef struct {
        int w;
        int cnt;
        int first;
    } hs_vec_t;
    hs_vec_t hs_tab[7];

    int n_tests = 0;
    int n_fail  = 0;

    // Line-level reference state
    int m_cnt, m_int, m_v, m_vfalls, m_mode, m_raised;
    // Per-line capture
    int hs_count, hs_first, probe_char, probe_int, probe_line, rst_char, line_no;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s (line %0d): got %0d, expected %0d", name, line_no, act, exp);
        end
    endtask

    task automatic reset_model();
        m_cnt = 0; m_int = 0; m_v = 0; m_vfalls = 0; m_mode = 0; m_raised = 0;
    endtask

    task automatic model_ack();
        m_int = 0;
        if (m_cnt >= 32) m_cnt -= 32;
    endtask

    task automatic model_clr();
        m_int = 0;
        m_cnt = 0;
    endtask

    task automatic model_fall();
        m_raised = 0;
        if (m_v != 0) m_vfalls++;
        if (m_v != 0 && m_vfalls == V_DELAY) begin
            if (m_cnt < 32) begin m_int = 1; m_raised = 1; end
            m_cnt = 0;
        end else if (m_cnt == INT_LINES - 1) begin
            m_cnt = 0; m_int = 1; m_raised = 1;
        end else begin
            m_cnt++;
        end
    endtask

    // One CRTC line of len characters, HSYNC high for the first w. ACK/CLR pulse
    // on the CLKEN clock of the given character (-1 = none).
    task automatic do_line(input int len, input int w, input int v, input int ack_c, input int clr_c);
        int mode_a, mode_b, fall_c, exp_vs, exp_hs, exp_first;
        bit aborted;
        mode_a = $urandom_range(0, 3);
        mode_b = mode_a ^ $urandom_range(1, 3);
        fall_c = w + 1;
        hs_count = 0; hs_first = -1; aborted = 0;
        for (int c = 0; c < len; c++) begin
            bus.HSYNC_IN = (c < w);
            bus.VSYNC_IN = v[0];
            bus.MODE_IN  = (c < 10) ? mode_a[1:0] : mode_b[1:0];
            bus.INT_ACK  = (c == ack_c);
            bus.INT_CLR  = (c == clr_c);
            bus.CLKEN    = 1'b1;
            @(posedge clk); #1;
            bus.INT_ACK = 1'b0; bus.INT_CLR = 1'b0; bus.CLKEN = 1'b0;
            if (bus.HSYNC_OUT) begin
                if (hs_first < 0) hs_first = c;
                hs_count++;
            end
            if (c == probe_char) begin probe_int = int'(bus.INT); probe_line = int'(bus.LINE_CNT); end
            if (c == rst_char) begin aborted = 1; break; end
            @(posedge clk); #1;
        end
        line_no++;
        if (aborted) return;

        m_mode = mode_a;
        if (v != 0 && m_v == 0) m_vfalls = 0;
        m_v = v;
        if (ack_c >= 0 && ack_c < fall_c) model_ack();
        if (clr_c >= 0 && clr_c < fall_c) model_clr();
        model_fall();
        if (ack_c >= fall_c && !(ack_c == fall_c && m_raised != 0)) model_ack();
        if (clr_c >= fall_c) model_clr();

        exp_vs = (m_v != 0 && m_vfalls >= V_DELAY && m_vfalls < V_DELAY + V_WIDTH) ? 1 : 0;
        exp_hs = (w > H_DELAY) ? ((w - H_DELAY < H_WIDTH) ? w - H_DELAY : H_WIDTH) : 0;
        exp_first = (exp_hs > 0) ? H_DELAY + 1 : -1;
        check("line_cnt", int'(bus.LINE_CNT), m_cnt);
        check("int", int'(bus.INT), m_int);
        check("vsync_out", int'(bus.VSYNC_OUT), exp_vs);
        check("mode", int'(bus.MODE), m_mode);
        check("hsync_width", hs_count, exp_hs);
        check("hsync_start", hs_first, exp_first);
        $display("[TB] line %0d w=%0d v=%0d ack=%0d clr=%0d cnt=%0d int=%0d vs=%0d hs=%0d mode=%0d",
                 line_no, w, v, ack_c, clr_c, bus.LINE_CNT, bus.INT, bus.VSYNC_OUT, hs_count, bus.MODE);
    endtask

    task automatic pulse_clr();
        bus.INT_CLR = 1'b1;
        @(posedge clk); #1;
        bus.INT_CLR = 1'b0;
        model_clr();
        check("clr_int", int'(bus.INT), 0);
        check("clr_cnt", int'(bus.LINE_CNT), 0);
    endtask

    task automatic count_vs_lines(input int pre, input int vlen, input int w, output int vs_lines);
        vs_lines = 0;
        for (int i = 1; i <= vlen; i++) begin
            do_line(24, w, 1, -1, -1);
            if (bus.VSYNC_OUT) vs_lines++;
            if (i == V_DELAY) begin
                check("resync_cnt", int'(bus.LINE_CNT), 0);
                check("resync_int", int'(bus.INT), (pre < 32) ? 1 : 0);
            end
        end
    endtask

    initial begin
        int vs_lines, rv, w, ack_c, clr_c;
        hs_tab[0] = '{14, 4, 3};
        hs_tab[1] = '{4, 2, 3};
        hs_tab[2] = '{2, 0, -1};
        hs_tab[3] = '{3, 1, 3};
        hs_tab[4] = '{5, 3, 3};
        hs_tab[5] = '{6, 4, 3};
        hs_tab[6] = '{1, 0, -1};

        bus.CLKEN = 0; bus.HSYNC_IN = 0; bus.VSYNC_IN = 0;
        bus.INT_ACK = 0; bus.INT_CLR = 0; bus.MODE_IN = 2'd3;
        probe_char = -1; rst_char = -1; line_no = 0;
        reset_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst_int", int'(bus.INT), 0);
        check("rst_hs", int'(bus.HSYNC_OUT), 0);
        check("rst_vs", int'(bus.VSYNC_OUT), 0);
        check("rst_mode", int'(bus.MODE), 0);
        check("rst_cnt", int'(bus.LINE_CNT), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Free-running counter, R0=63, HSYNC width 14; ACK 10 clocks after first INT
        for (int n = 1; n <= 104; n++) begin
            probe_char = (n == 52 || n == 104) ? 15 : -1;
            do_line(64, 14, 0, (n == 52) ? 20 : -1, -1);
            if (n == 52 || n == 104) begin
                check("wrap_int", probe_int, 1);
                check("wrap_cnt", probe_line, 0);
            end
        end
        probe_char = -1;

        // Resync late in the frame: no interrupt; then a 16-line VSYNC
        pulse_clr();
        repeat (40) do_line(24, 6, 0, -1, -1);
        count_vs_lines(40, 16, 6, vs_lines);
        repeat (2) do_line(24, 6, 0, -1, -1);

        // Resync early in the frame: interrupt; VSYNC held 40 lines
        pulse_clr();
        repeat (10) do_line(24, 6, 0, -1, -1);
        count_vs_lines(10, 40, 6, vs_lines);
        check("vsync_len_26", vs_lines, V_WIDTH);
        repeat (2) do_line(24, 6, 0, -1, -1);

        // Priority: CLR and ACK coincident with the wrap fall (char 7 for w=6)
        pulse_clr();
        repeat (51) do_line(24, 6, 0, -1, -1);
        probe_char = 7;
        do_line(24, 6, 0, -1, 7);
        check("clr_wrap_int", probe_int, 0);
        check("clr_wrap_cnt", probe_line, 0);
        probe_char = -1;
        repeat (51) do_line(24, 6, 0, -1, -1);
        probe_char = 7;
        do_line(24, 6, 0, 7, -1);
        check("ack_wrap_int", probe_int, 1);
        check("ack_wrap_cnt", probe_line, 0);
        probe_char = -1;

        // Monitor HSYNC width table
        for (int i = 0; i < 7; i++) begin
            do_line(24, hs_tab[i].w, 0, -1, -1);
            check("tab_hs_width", hs_count, hs_tab[i].cnt);
            check("tab_hs_start", hs_first, hs_tab[i].first);
        end

        // Asynchronous reset while both monitor pulses are active
        repeat (3) do_line(24, 14, 1, -1, -1);
        rst_char = 4;
        do_line(24, 14, 1, -1, -1);
        check("pre_rst_hs", int'(bus.HSYNC_OUT), 1);
        check("pre_rst_vs", int'(bus.VSYNC_OUT), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_int", int'(bus.INT), 0);
        check("async_rst_hs", int'(bus.HSYNC_OUT), 0);
        check("async_rst_vs", int'(bus.VSYNC_OUT), 0);
        check("async_rst_mode", int'(bus.MODE), 0);
        check("async_rst_cnt", int'(bus.LINE_CNT), 0);
        bus.HSYNC_IN = 0; bus.VSYNC_IN = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rst_char = -1;
        reset_model();

        // Randomized lines: widths, VSYNC lengths, ACK/CLR placement
        rv = 0;
        for (int n = 0; n < 150; n++) begin
            if (rv == 0 && $urandom_range(0, 24) == 0) rv = 1;
            else if (rv == 1 && $urandom_range(0, 17) == 0) rv = 0;
            w = $urandom_range(1, 14);
            ack_c = ($urandom_range(0, 4) == 0) ? $urandom_range(0, w + 4) : -1;
            clr_c = ($urandom_range(0, 39) == 0) ? w + 1 + $urandom_range(0, 3) : -1;
            do_line(24, w, rv, ack_c, clr_c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
